// File: rtl/demux_seq_driver.sv
// demux_seq_driver: sequencer that feeds a 1-to-NCH demultiplexer.
// A word is accepted over valid/ready. The select s then walks channels
// 0..NCH-1, with i carrying the matching word bit for DWELL cycles per
// channel. done pulses in the first idle cycle after the last channel.
// All outputs come straight from flops.
//
// Optional build macro: DEMUX_SEQ_SKIP_ZERO_EN
//   When defined, channels whose word bit is 0 are skipped entirely.
//   An all-zero word completes immediately with a done pulse.
module demux_seq_driver #(
  parameter int SEL_W = 2,
  parameter int NCH   = 4,    // must equal 2**SEL_W
  parameter int DWELL = 1     // 1..255 cycles per channel
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NCH-1:0]   in_data,
  output logic [SEL_W-1:0] s,
  output logic             i,
  output logic             busy,
  output logic             done
);

  typedef enum logic {IDLE, DRIVE} state_t;

  localparam logic [7:0]       DWELL_LAST = 8'(DWELL - 1);
  localparam logic [SEL_W-1:0] CH_LAST    = SEL_W'(NCH - 1);

  state_t           state_reg, state_next;
  logic [NCH-1:0]   word_reg, word_next;
  logic [SEL_W-1:0] chan_reg, chan_next;
  logic [7:0]       dwell_reg, dwell_next;
  logic [SEL_W-1:0] s_reg, s_next;
  logic             i_reg, i_next;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;
  logic             ready_reg, ready_next;

  logic             accept;
  logic             first_found;
  logic [SEL_W-1:0] first_ch;
  logic             adv_found;
  logic [SEL_W-1:0] adv_ch;

  assign accept   = in_valid & ready_reg;
  assign s        = s_reg;
  assign i        = i_reg;
  assign busy     = busy_reg;
  assign done     = done_reg;
  assign in_ready = ready_reg;

  // Channel lookahead: first channel of a new word and the channel after the current one.
  always_comb begin
    first_found = 1'b0;
    first_ch    = '0;
    adv_found   = 1'b0;
    adv_ch      = '0;
`ifdef DEMUX_SEQ_SKIP_ZERO_EN
    // Descending scans so the lowest qualifying channel is the one kept.
    for (int k = NCH - 1; k >= 0; k--) begin
      if (in_data[k]) begin
        first_found = 1'b1;
        first_ch    = SEL_W'(k);
      end
      if (k > int'(chan_reg) && word_reg[k]) begin
        adv_found = 1'b1;
        adv_ch    = SEL_W'(k);
      end
    end
`else
    first_found = 1'b1;
    first_ch    = '0;
    adv_found   = (chan_reg != CH_LAST);
    adv_ch      = chan_reg + 1'b1;
`endif
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      word_reg  <= '0;
      chan_reg  <= '0;
      dwell_reg <= '0;
      s_reg     <= '0;
      i_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      done_reg  <= 1'b0;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      word_reg  <= word_next;
      chan_reg  <= chan_next;
      dwell_reg <= dwell_next;
      s_reg     <= s_next;
      i_reg     <= i_next;
      busy_reg  <= busy_next;
      done_reg  <= done_next;
      ready_reg <= ready_next;
    end
  end

  // Next state plus word/channel/dwell bookkeeping.
  always_comb begin
    state_next = state_reg;
    word_next  = word_reg;
    chan_next  = chan_reg;
    dwell_next = dwell_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          word_next  = in_data;
          chan_next  = first_ch;
          dwell_next = '0;
          // An all-zero word in skip mode never leaves IDLE.
          state_next = first_found ? DRIVE : IDLE;
        end
      end
      DRIVE: begin
        if (dwell_reg < DWELL_LAST) begin
          dwell_next = dwell_reg + 8'd1;
        end else if (adv_found) begin
          chan_next  = adv_ch;
          dwell_next = '0;
        end else begin
          state_next = IDLE;
          chan_next  = '0;
          dwell_next = '0;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered outputs; the default is the idle pattern.
  always_comb begin
    s_next     = '0;
    i_next     = 1'b0;
    busy_next  = 1'b0;
    done_next  = 1'b0;
    ready_next = 1'b1;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          if (first_found) begin
            s_next     = first_ch;
            i_next     = in_data[first_ch];
            busy_next  = 1'b1;
            ready_next = 1'b0;
          end else begin
            done_next  = 1'b1;
          end
        end
      end
      DRIVE: begin
        if (dwell_reg < DWELL_LAST) begin
          s_next     = s_reg;
          i_next     = i_reg;
          busy_next  = 1'b1;
          ready_next = 1'b0;
        end else if (adv_found) begin
          s_next     = adv_ch;
          i_next     = word_reg[adv_ch];
          busy_next  = 1'b1;
          ready_next = 1'b0;
        end else begin
          done_next  = 1'b1;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: doc/demux_seq_driver.md
Name: demux_seq_driver

Overview:
- Upstream sequencer for the 1-to-4 demultiplexer stage.
- Accepts a 4-bit parallel word over a valid/ready handshake.
- Walks the demux select through channels 0..NCH-1, driving the demux data input with the matching word bit for DWELL cycles per channel.
- Pulses done when the word has been fully distributed.

Parameters:
- SEL_W, 2, select width; drives demux s input.
- NCH, 4, channel count; must equal 2**SEL_W.
- DWELL, 1, cycles each channel is held on s/i; legal range 1..255.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  upstream word valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  NCH  word; bit k goes to channel k
- s  output  SEL_W  demux select, registered
- i  output  1  demux data input, registered
- busy  output  1  high while a word is being driven onto s/i
- done  output  1  one-cycle pulse after the last channel of a word

Behaviour:
- Reset values (async, rst_n=0):
  - s=0, i=0, busy=0, done=0, in_ready=1.
  - Internal word register = 0, channel counter = 0, dwell counter = 0.
  - State = IDLE.
- Reset mid-operation:
  - Aborts immediately; held word is discarded.
  - No done pulse is produced.
  - Outputs return to reset values asynchronously.
- States: IDLE, DRIVE.
- IDLE:
  - in_ready=1, busy=0, s=0, i=0.
  - Accept on the rising edge where in_valid=1 and in_ready=1.
  - On accept: latch in_data; set s<=0, i<=in_data[0], busy<=1, in_ready<=0; channel=0, dwell=0; go to DRIVE.
- DRIVE:
  - in_ready=0; in_valid is ignored.
  - s=channel, i=word[channel].
  - Each channel is held exactly DWELL cycles.
  - While dwell<DWELL-1: increment dwell.
  - Otherwise, if channel<NCH-1: channel++, dwell=0, s<=channel+1, i<=word[channel+1].
  - Otherwise (last cycle of the last channel): s<=0, i<=0, busy<=0, done<=1, in_ready<=1; go to IDLE.
- done:
  - High for exactly one cycle, coinciding with the first IDLE cycle.
  - Deasserts on the following edge unless a new word's completion re-asserts it.
- Back-to-back words:
  - A word presented with in_valid=1 during the done cycle is accepted on that edge.
  - The next word's s=0 drive therefore starts with zero idle gap.
- Latency:
  - First channel is on s/i in the cycle after the accept edge.
  - Accept to done assertion = NCH*DWELL + 1 edges.
  - Throughput: one word per NCH*DWELL+1 cycles.
- Width rules:
  - Channel counter is SEL_W bits.
  - Dwell counter is 8 bits.
  - No wrap occurs in normal operation; the counter compare ends the word before wrap.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Optional Feature:
- Macro: DEMUX_SEQ_SKIP_ZERO_EN.
- Defined:
  - Channels whose word bit is 0 are skipped; no dwell cycles are spent on them.
  - s advances directly to the next channel whose bit is 1; i is always 1 while busy.
  - All-zero word: accepted normally, busy stays 0, done pulses in the cycle after the accept edge; s and i stay 0.
  - Accept to done = (popcount(word)*DWELL)+1 edges.
- Undefined:
  - Every channel is driven for DWELL cycles regardless of data value, as specified above.

Test Plan:
- Reset, DWELL=1 -> s=00, i=0, busy=0, done=0, in_ready=1; release rst_n, no in_valid for 5 cycles -> outputs unchanged.
- DWELL=1, present in_data=4'b1011 with in_valid for one cycle:
  - Next 4 cycles show (s,i) = (00,1), (01,1), (10,0), (11,1), with busy=1, in_ready=0.
  - Then a cycle with done=1, busy=0, in_ready=1.
- DWELL=3, in_data=4'b0110 -> each (s,i) pair is held 3 cycles: (00,0)x3, (01,1)x3, (10,1)x3, (11,0)x3; done asserts 13 edges after accept.
- Back-to-back: hold in_valid=1 with words 4'b1111 then 4'b0001 -> the second word is accepted in the done cycle of the first; s goes 11 -> 00 with no idle gap; i=1 for s=00 of the second word.
- Reset mid-word: assert rst_n=0 while s=10 on word 4'b1111 -> s=0, i=0, busy=0 immediately; no done pulse after release; in_ready=1.
- With DEMUX_SEQ_SKIP_ZERO_EN, DWELL=1:
  - in_data=4'b1001 -> (s,i) = (00,1), (11,1), then done.
  - in_data=4'b0000 -> busy never asserts; done pulses in the cycle after accept.
